// File: rtl/function_lut_pkg.sv
// Shared widths, value types and helpers for the function_lut arbitration slice.
package function_lut_pkg;

  localparam int unsigned W_X_DEF = 4;
  localparam int unsigned W_Y_DEF = 8;

  typedef logic signed [W_X_DEF-1:0] x_t;
  typedef logic signed [W_Y_DEF-1:0] y_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 2) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/function_lut_arb_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or above ptr, wrapping.
module rr_arbiter
  import function_lut_pkg::*;
#(
  parameter  int unsigned N   = 4,
  localparam int unsigned IDW = id_w(N)
) (
  input  logic [N-1:0]   elig,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx
);

  // Walk the lanes starting from ptr and take the first eligible one.
  always_comb begin
    logic           found;
    int unsigned    j;
    logic [IDW-1:0] cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j    = (32'(ptr) + k) % N;
      cand = IDW'(j);
      if (!found && elig[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/function_lut_arb.sv
// Shares one pipelined LUT port among N_REQ requesters and routes results back by tag.
module function_lut_arb
  import function_lut_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W_X   = W_X_DEF,
  parameter int unsigned W_Y   = W_Y_DEF,
  parameter int unsigned LAT   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*W_X-1:0]   req_x,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   lut_valid,
  output logic [W_X-1:0]         lut_x,
  input  logic [W_Y-1:0]         lut_y,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [N_REQ*W_Y-1:0]   resp_y,
  output logic [N_REQ-1:0]       inflight,
  output logic [15:0]            issue_cnt
);

  localparam int unsigned IDW = id_w(N_REQ);

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_idx;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  logic             grant_any;
  logic [LAT-1:0]   tag_v;
  logic [IDW-1:0]   tag_id [LAT];
  logic             done;
  logic [IDW-1:0]   done_id;
  logic [N_REQ-1:0] clr_mask;

  // No grants while reset is asserted; one outstanding request per lane.
  assign elig = req_valid & ~inflight & {N_REQ{rst_n}};

  rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
    .elig  (elig),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign req_ready = grant;
  assign grant_any = |grant;
  assign lut_valid = grant_any;
  assign done      = tag_v[LAT-1];
  assign done_id   = tag_id[LAT-1];

  // One-hot mux of the granted lane's code onto the shared LUT input.
  always_comb begin
    lut_x = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) lut_x = req_x[i*W_X +: W_X];
    end
  end

  // Lane whose LUT result is on lut_y this cycle.
  always_comb begin
    clr_mask = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      clr_mask[i] = done && (done_id == IDW'(i));
    end
  end

  // Pointer, inflight bookkeeping and grant counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      inflight  <= '0;
      issue_cnt <= '0;
    end else begin
      if (grant_any) begin
        rr_ptr <= (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);
      end
      inflight  <= (inflight & ~clr_mask) | grant;
      issue_cnt <= issue_cnt + 16'(grant_any);
    end
  end

  // Requester-ID shift register aligned to the LUT latency; reset drops results in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int unsigned s = 0; s < LAT; s++) tag_id[s] <= '0;
    end else begin
      tag_v[0]  <= grant_any;
      tag_id[0] <= grant_idx;
      for (int unsigned s = 1; s < LAT; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  // Capture the aligned LUT result into the owning lane's response register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid <= '0;
      resp_y     <= '0;
    end else begin
      resp_valid <= clr_mask;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (clr_mask[i]) resp_y[i*W_Y +: W_Y] <= lut_y;
      end
    end
  end

endmodule
